// File: rtl/frame_seq_pkg.sv
// Shared state encoding, default sizing constants and a width helper for the
// acquisition/FFT frame sequencer.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StStart   = 2'd2,
    StProcess = 2'd3
  } seq_state_e;

  localparam int unsigned DefPresc    = 10000000;
  localparam int unsigned DefFrameLen = 1024;
  localparam int unsigned DefAddrW    = 10;
  localparam int unsigned DefTimeout  = 262144;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESC clocks, independent of
// any downstream state.
module rate_tick_gen
  import frame_seq_pkg::*;
#(
  parameter int unsigned PRESC = DefPresc
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(PRESC);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Schedules one acquisition frame per tick into the time buffer, kicks the FFT
// and waits for it, counting dropped ticks and aborting a hung FFT.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned PRESC     = DefPresc,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic              freeze,
  output logic              time_en,
  output logic              time_we,
  output logic [ADDR_W-1:0] time_addr,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [15:0]       frame_count,
  output logic [7:0]        overrun_count,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  localparam int unsigned ToW = cnt_width(TIMEOUT);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ToW-1:0]    ToLast   = ToW'(TIMEOUT - 1);

  logic tick;

  rate_tick_gen #(
    .PRESC (PRESC)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [15:0]       frame_q, frame_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              terr_q, terr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      to_q    <= '0;
      frame_q <= '0;
      ovr_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      to_q    <= to_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    to_d      = to_q;
    frame_d   = frame_q;
    ovr_d     = ovr_q;
    terr_d    = terr_q;
    time_en   = 1'b0;
    time_we   = 1'b0;
    fft_start = 1'b0;

    // Only one frame in flight: a tick arriving while busy is dropped and counted.
    if (tick && (state_q != StIdle) && (ovr_q != 8'hff)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (tick && !freeze) begin
          state_d = StCapture;
          addr_d  = '0;
        end
      end
      StCapture: begin
        time_en = 1'b1;
        time_we = sample_valid;
        if (sample_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LastAddr) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        fft_start = 1'b1;
        to_d      = '0;
        state_d   = StProcess;
      end
      StProcess: begin
        to_d = to_q + ToW'(1);
        if (fft_done) begin
          frame_d = frame_q + 16'd1;
          state_d = StIdle;
        end else if (to_q == ToLast) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign time_addr     = addr_q;
  assign frame_count   = frame_q;
  assign overrun_count = ovr_q;
  assign timeout_err   = terr_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: nominal frame, overrun, timeout, freeze,
// mid-frame reset, and overrun saturation on a fast-tick second instance.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, sample_valid, freeze, fft_done;
  logic       time_en, time_we, fft_start, timeout_err;
  logic [2:0] time_addr;
  logic [15:0] frame_count;
  logic [7:0] overrun_count;
  logic [1:0] state_dbg;

  logic       b_rst_n, b_sample_valid, b_freeze, b_fft_done;
  logic       b_time_en, b_time_we, b_fft_start, b_timeout_err;
  logic [2:0] b_time_addr;
  logic [15:0] b_frame_count;
  logic [7:0] b_overrun_count;
  logic [1:0] b_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int wr_cnt    = 0;

  always #5 clk = ~clk;

  frame_sequencer #(
    .PRESC     (100),
    .FRAME_LEN (8),
    .ADDR_W    (3),
    .TIMEOUT   (50)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .freeze        (freeze),
    .time_en       (time_en),
    .time_we       (time_we),
    .time_addr     (time_addr),
    .fft_start     (fft_start),
    .fft_done      (fft_done),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  frame_sequencer #(
    .PRESC     (4),
    .FRAME_LEN (8),
    .ADDR_W    (3),
    .TIMEOUT   (4096)
  ) dut_sat (
    .clk           (clk),
    .rst_n         (b_rst_n),
    .sample_valid  (b_sample_valid),
    .freeze        (b_freeze),
    .time_en       (b_time_en),
    .time_we       (b_time_we),
    .time_addr     (b_time_addr),
    .fft_start     (b_fft_start),
    .fft_done      (b_fft_done),
    .frame_count   (b_frame_count),
    .overrun_count (b_overrun_count),
    .timeout_err   (b_timeout_err),
    .state_dbg     (b_state_dbg)
  );

  always @(posedge clk) begin
    if (fft_start) start_cnt <= start_cnt + 1;
    if (time_we)   wr_cnt    <= wr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the falling edge following rising edge number c after release.
  task automatic at(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset(input logic frz);
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid = 1'b0;
    fft_done = 1'b0;
    freeze = frz;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", state_dbg, 0);
    check_eq("rst_addr", time_addr, 0);
    check_eq("rst_en_we_start", {time_en, time_we, fft_start}, 0);
    check_eq("rst_counts", {frame_count, overrun_count, timeout_err}, 0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int s0, w0;
    rst_n = 1'b0; sample_valid = 1'b0; freeze = 1'b0; fft_done = 1'b0;
    b_rst_n = 1'b0; b_sample_valid = 1'b0; b_freeze = 1'b0; b_fft_done = 1'b0;

    // Nominal frame: sample every 3 cycles, FFT done 10 cycles after start.
    do_reset(1'b0);
    s0 = start_cnt; w0 = wr_cnt;
    at(99);  #1; check_eq("nom_idle_before_tick", state_dbg, 0);
    at(100); #1; check_eq("nom_capture", state_dbg, 1);
    check_eq("nom_time_en", time_en, 1);
    check_eq("nom_we_idle_sample", time_we, 0);
    for (int i = 0; i < 8; i++) begin
      at(100 + 3 * i); sample_valid = 1'b1; #1;
      check_eq("nom_we", time_we, 1);
      check_eq("nom_addr", time_addr, i);
      at(101 + 3 * i); sample_valid = 1'b0;
    end
    #1;
    check_eq("nom_fft_start", fft_start, 1);
    check_eq("nom_state_start", state_dbg, 2);
    at(123); #1;
    check_eq("nom_start_one_cycle", fft_start, 0);
    check_eq("nom_state_process", state_dbg, 3);
    at(132); fft_done = 1'b1;
    at(133); fft_done = 1'b0; #1;
    check_eq("nom_back_idle", state_dbg, 0);
    check_eq("nom_frame_count", frame_count, 1);
    check_eq("nom_start_pulses", start_cnt - s0, 1);
    check_eq("nom_writes", wr_cnt - w0, 8);
    check_eq("nom_overrun", overrun_count, 0);

    // Overrun: tick lands while in PROCESS, FFT finishes before timeout.
    do_reset(1'b0);
    at(100); #1; check_eq("ovr_capture", state_dbg, 1);
    for (int i = 0; i < 8; i++) begin
      at(160 + i); sample_valid = 1'b1; #1;
      check_eq("ovr_addr", time_addr, i);
    end
    at(168); sample_valid = 1'b0; #1;
    check_eq("ovr_fft_start", fft_start, 1);
    at(199); #1; check_eq("ovr_count_before", overrun_count, 0);
    at(200); #1; check_eq("ovr_count_after", overrun_count, 1);
    check_eq("ovr_still_process", state_dbg, 3);
    at(205); fft_done = 1'b1;
    at(206); fft_done = 1'b0; #1;
    check_eq("ovr_idle", state_dbg, 0);
    check_eq("ovr_frame_count", frame_count, 1);
    check_eq("ovr_no_timeout", timeout_err, 0);
    at(250); fft_done = 1'b1; sample_valid = 1'b1; #1;
    check_eq("ovr_we_outside_capture", time_we, 0);
    at(251); fft_done = 1'b0; sample_valid = 1'b0; #1;
    check_eq("ovr_done_ignored", frame_count, 1);
    check_eq("ovr_addr_unchanged", time_addr, 0);
    at(299); #1; check_eq("ovr_no_early_capture", state_dbg, 0);
    at(300); #1; check_eq("ovr_next_capture", state_dbg, 1);

    // Timeout: FFT never completes.
    do_reset(1'b0);
    at(100); sample_valid = 1'b1;
    at(108); sample_valid = 1'b0; #1;
    check_eq("to_fft_start", fft_start, 1);
    at(158); #1;
    check_eq("to_state_pre", state_dbg, 3);
    check_eq("to_err_pre", timeout_err, 0);
    at(159); #1;
    check_eq("to_state_post", state_dbg, 0);
    check_eq("to_err_post", timeout_err, 1);
    check_eq("to_frame_count", frame_count, 0);
    at(165); fft_done = 1'b1;
    at(166); fft_done = 1'b0; #1;
    check_eq("to_late_done_ignored", frame_count, 0);
    at(200); #1;
    check_eq("to_next_capture", state_dbg, 1);
    check_eq("to_err_sticky", timeout_err, 1);

    // Freeze across three ticks, then release; then reset mid-frame.
    do_reset(1'b1);
    s0 = start_cnt;
    at(100); #1; check_eq("frz_tick1", state_dbg, 0);
    at(200); #1; check_eq("frz_tick2", state_dbg, 0);
    at(300); #1; check_eq("frz_tick3", state_dbg, 0);
    check_eq("frz_overrun", overrun_count, 0);
    at(350); freeze = 1'b0;
    at(399); #1; check_eq("frz_idle_pre", state_dbg, 0);
    at(400); #1; check_eq("frz_capture", state_dbg, 1);
    sample_valid = 1'b1;
    at(404); sample_valid = 1'b0; #1;
    check_eq("mid_addr_4", time_addr, 4);
    rst_n = 1'b0;
    at(405); #1;
    check_eq("mid_state", state_dbg, 0);
    check_eq("mid_addr", time_addr, 0);
    check_eq("mid_en_we_start", {time_en, time_we, fft_start}, 0);
    check_eq("mid_counts", {frame_count, overrun_count, timeout_err}, 0);
    at(407); rst_n = 1'b1;
    at(420); #1;
    check_eq("mid_no_fft_start", start_cnt - s0, 0);
    check_eq("mid_stays_idle", state_dbg, 0);

    // Saturation on the fast-tick instance with a hung FFT.
    @(negedge clk);
    b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1;
    b_sample_valid = 1'b1;
    cyc = 0;
    at(100);  #1; check_eq("sat_count_24", b_overrun_count, 24);
    at(1020); #1; check_eq("sat_count_254", b_overrun_count, 254);
    at(1024); #1; check_eq("sat_count_255", b_overrun_count, 255);
    at(1300); #1; check_eq("sat_hold_255", b_overrun_count, 255);
    check_eq("sat_process", b_state_dbg, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
